// File: rtl/audio_smoother.sv
// Stereo moving-average filter: averages the last 2^LOG2_TAPS samples per channel
// using a ring buffer and running sum, with a registered pass-through bypass.
module audio_smoother #(
    parameter int LOG2_TAPS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               new_audio_in,
    input  logic signed [31:0] l_audio_in,
    input  logic signed [31:0] r_audio_in,
    output logic signed [31:0] l_audio_out,
    output logic signed [31:0] r_audio_out,
    output logic               audio_out_valid,
    output logic               primed
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = 32 + LOG2_TAPS;
    localparam logic [LOG2_TAPS-1:0] LAST = LOG2_TAPS'(TAPS - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                 state;
    logic [LOG2_TAPS-1:0]   count;
    logic [LOG2_TAPS-1:0]   wr_ptr;
    logic signed [31:0]     l_buf [TAPS];
    logic signed [31:0]     r_buf [TAPS];
    logic signed [SW-1:0]   l_sum, r_sum;
    logic signed [SW-1:0]   l_sum_next, r_sum_next;
    logic signed [31:0]     l_avg, r_avg;

    function automatic logic signed [SW-1:0] sext(input logic signed [31:0] x);
        return {{LOG2_TAPS{x[31]}}, x};
    endfunction

    // Selecting bits above the low LOG2_TAPS is the arithmetic shift (floor toward -inf).
    always_comb begin
        l_sum_next = l_sum + sext(l_audio_in) - sext(l_buf[wr_ptr]);
        r_sum_next = r_sum + sext(r_audio_in) - sext(r_buf[wr_ptr]);
        l_avg      = l_sum_next[LOG2_TAPS +: 32];
        r_avg      = r_sum_next[LOG2_TAPS +: 32];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                l_buf[i] <= '0;
                r_buf[i] <= '0;
            end
            l_sum           <= '0;
            r_sum           <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            state           <= FILL;
            l_audio_out     <= '0;
            r_audio_out     <= '0;
            audio_out_valid <= 1'b0;
        end else begin
            audio_out_valid <= new_audio_in;
            if (new_audio_in) begin
                l_buf[wr_ptr] <= l_audio_in;
                r_buf[wr_ptr] <= r_audio_in;
                l_sum         <= l_sum_next;
                r_sum         <= r_sum_next;
                wr_ptr        <= wr_ptr + 1'b1;
                l_audio_out   <= enable ? l_avg : l_audio_in;
                r_audio_out   <= enable ? r_avg : r_audio_in;
                // History fills regardless of enable, so RUN is reached on sample count alone.
                case (state)
                    FILL: begin
                        if (count == LAST) state <= RUN;
                        else               count <= count + 1'b1;
                    end
                    RUN: ;
                    default: state <= FILL;
                endcase
            end
        end
    end

    assign primed = (state == RUN);

endmodule

// File: tb/tb_audio_smoother.sv
// Directed self-checking bench for audio_smoother with LOG2_TAPS = 3 (8-tap window).
module tb_audio_smoother;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b1;
    logic               new_audio_in = 1'b0;
    logic signed [31:0] l_audio_in = '0;
    logic signed [31:0] r_audio_in = '0;
    logic signed [31:0] l_audio_out, r_audio_out;
    logic               audio_out_valid, primed;

    int checks = 0;
    int errors = 0;

    audio_smoother #(.LOG2_TAPS(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .new_audio_in    (new_audio_in),
        .l_audio_in      (l_audio_in),
        .r_audio_in      (r_audio_in),
        .l_audio_out     (l_audio_out),
        .r_audio_out     (r_audio_out),
        .audio_out_valid (audio_out_valid),
        .primed          (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] l_exp, input logic [31:0] r_exp,
                                input logic valid_exp);
        check({tag, " l"}, l_audio_out, l_exp);
        check({tag, " r"}, r_audio_out, r_exp);
        check({tag, " valid"}, {31'b0, audio_out_valid}, {31'b0, valid_exp});
    endtask

    // Drive one sample at a falling edge; return at the next falling edge, after it was taken.
    task automatic apply_stimulus(input logic [31:0] l, input logic [31:0] r, input logic en);
        @(negedge clk);
        l_audio_in   = l;
        r_audio_in   = r;
        enable       = en;
        new_audio_in = 1'b1;
        @(negedge clk);
        new_audio_in = 1'b0;
    endtask

    // One sample, then a 3-cycle gap where outputs must hold with valid low.
    task automatic spaced_sample(input string tag, input logic [31:0] l, input logic [31:0] r,
                                 input logic en, input logic [31:0] l_exp, input logic [31:0] r_exp);
        apply_stimulus(l, r, en);
        check_output(tag, l_exp, r_exp, 1'b1);
        repeat (2) @(negedge clk);
        check_output({tag, " hold"}, l_exp, r_exp, 1'b0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output({tag, " async"}, 32'h0, 32'h0, 1'b0);
        check({tag, " primed"}, {31'b0, primed}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        longint l_model, r_model;
        int     valid_count;

        // Power-up reset
        #1;
        check_output("por", 32'h0, 32'h0, 1'b0);
        check("por primed", {31'b0, primed}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("post release", 32'h0, 32'h0, 1'b0);

        // DC ramp up then down
        $display("[TB] DC ramp");
        for (int k = 1; k <= 8; k++) begin
            spaced_sample("ramp up", 32'h800, 32'h800, 1'b1, 32'(k * 32'h100), 32'(k * 32'h100));
            check("ramp primed", {31'b0, primed}, (k == 8) ? 32'h1 : 32'h0);
        end
        for (int k = 7; k >= 0; k--)
            spaced_sample("ramp down", 32'h0, 32'h0, 1'b1, 32'(k * 32'h100), 32'(k * 32'h100));

        // Negative floor: -1/8 floors to -1, -9/8 floors to -2
        pulse_reset("floor reset");
        spaced_sample("floor first", 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        for (int k = 1; k <= 7; k++)
            spaced_sample("floor zeros", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        spaced_sample("floor drained", 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);

        // Extremes, back-to-back, wrapping the ring twice
        $display("[TB] extremes back-to-back");
        pulse_reset("extreme reset");
        valid_count = 0;
        @(negedge clk);
        l_audio_in   = 32'h7FFF_FFFF;
        r_audio_in   = 32'h8000_0000;
        enable       = 1'b1;
        new_audio_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) new_audio_in = 1'b0;
            if (audio_out_valid) valid_count++;
            l_model = ((k < 8 ? k : 8) * longint'(32'sh7FFF_FFFF)) >>> 3;
            r_model = ((k < 8 ? k : 8) * longint'(32'sh8000_0000)) >>> 3;
            check_output("extreme", l_model[31:0], r_model[31:0], 1'b1);
        end
        @(negedge clk);
        check("extreme valid after", {31'b0, audio_out_valid}, 32'h0);
        check("extreme pulse count", 32'(valid_count), 32'd16);
        check("extreme primed", {31'b0, primed}, 32'h1);

        // Enable bypass and re-enable with full history
        pulse_reset("bypass reset");
        for (int k = 1; k <= 8; k++)
            apply_stimulus(32'h1000, 32'h1000, 1'b1);
        check_output("bypass primed avg", 32'h1000, 32'h1000, 1'b1);
        spaced_sample("bypass off", 32'h5000, 32'h5000, 1'b0, 32'h5000, 32'h5000);
        // Window now holds six 0x1000 and two 0x5000 samples
        spaced_sample("bypass on", 32'h5000, 32'h5000, 1'b1, 32'h2000, 32'h2000);

        // Mid-stream reset discards history; sample in first cycle after release is accepted
        pulse_reset("mid reset a");
        for (int k = 1; k <= 5; k++)
            spaced_sample("mid fill", 32'h800, 32'h800, 1'b1, 32'(k * 32'h100), 32'(k * 32'h100));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("mid async", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset        = 1'b0;
        l_audio_in   = 32'h800;
        r_audio_in   = 32'h800;
        new_audio_in = 1'b1;
        @(negedge clk);
        new_audio_in = 1'b0;
        check_output("mid restart", 32'h100, 32'h100, 1'b1);
        check("mid primed", {31'b0, primed}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
